// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war match controller: FSM state
// encoding and active-low seven-segment digit patterns (gfedcba).
package tow_pkg;

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_HOLD  = 2'd1,
      ST_CLEAR = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Segment order gfedcba, a lit segment is 0.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/tow_match_ctrl_if.sv
// Match-controller bus: win flags and start request in, freeze/reset
// controls, score digits and match result out.
interface tow_match_ctrl_if;

   logic       win_l;
   logic       win_r;
   logic       start;
   logic [1:0] idle;
   logic       round_reset;
   logic [6:0] hex_l;
   logic [6:0] hex_r;
   logic       match_over;
   logic [1:0] champion;

   // Driver side: score blocks and the match-start control.
   modport master (
      output win_l, win_r, start,
      input  idle, round_reset, hex_l, hex_r, match_over, champion
   );

   // Controller side.
   modport slave (
      input  win_l, win_r, start,
      output idle, round_reset, hex_l, hex_r, match_over, champion
   );

endinterface

// File: rtl/tow_seg7.sv
// Decimal digit to active-low seven-segment pattern; values above 9 blank.
module tow_seg7
   import tow_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   // Pure lookup from the 4-bit count to the gfedcba pattern.
   always_comb begin
      unique case (value)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/tow_match_ctrl.sv
// Tug-of-war match controller: counts round wins per side, freezes the
// board after each round, resets the score blocks, and declares a champion.
module tow_match_ctrl
   import tow_pkg::*;
#(
   parameter int WIN_ROUNDS  = 7,
   parameter int HOLD_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   tow_match_ctrl_if.slave  bus
);

   localparam logic [3:0] WIN_CNT   = 4'(WIN_ROUNDS);
   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state, state_n;
   logic [3:0] cnt_l, cnt_l_n;
   logic [3:0] cnt_r, cnt_r_n;
   logic [7:0] hold_cnt, hold_cnt_n;
   logic       win_l_q, win_r_q;
   logic       rise_l, rise_r;

   // Only a fresh 0->1 transition counts; a flag held high is one event.
   assign rise_l = bus.win_l & ~win_l_q;
   assign rise_r = bus.win_r & ~win_r_q;

   // State, counts and edge-detect registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ST_PLAY;
         cnt_l    <= '0;
         cnt_r    <= '0;
         hold_cnt <= '0;
         win_l_q  <= 1'b0;
         win_r_q  <= 1'b0;
      end else begin
         state    <= state_n;
         cnt_l    <= cnt_l_n;
         cnt_r    <= cnt_r_n;
         hold_cnt <= hold_cnt_n;
         win_l_q  <= bus.win_l;
         win_r_q  <= bus.win_r;
      end
   end

   // Next-state and next-count logic.
   // NOTE: every variable gets a default first so no path infers a latch.
   always_comb begin
      state_n    = state;
      cnt_l_n    = cnt_l;
      cnt_r_n    = cnt_r;
      hold_cnt_n = hold_cnt;
      unique case (state)
         ST_PLAY: begin
            if (rise_l && rise_r) begin
               state_n = ST_CLEAR;              // tie: no score, straight to clear
            end else if (rise_l) begin
               if (cnt_l < WIN_CNT) cnt_l_n = cnt_l + 4'd1;
               hold_cnt_n = '0;
               state_n    = ST_HOLD;
            end else if (rise_r) begin
               if (cnt_r < WIN_CNT) cnt_r_n = cnt_r + 4'd1;
               hold_cnt_n = '0;
               state_n    = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (hold_cnt == HOLD_LAST) state_n = ST_CLEAR;
            else                       hold_cnt_n = hold_cnt + 8'd1;
         end
         ST_CLEAR: begin
            if (cnt_l == WIN_CNT || cnt_r == WIN_CNT) state_n = ST_DONE;
            else                                      state_n = ST_PLAY;
         end
         ST_DONE: begin
            // A new match reuses CLEAR for its single round_reset pulse;
            // with counts zeroed, CLEAR then falls through to PLAY.
            if (bus.start) begin
               cnt_l_n = '0;
               cnt_r_n = '0;
               state_n = ST_CLEAR;
            end
         end
         default: state_n = ST_PLAY;
      endcase
   end

   // Outputs decoded purely from registered state and counts.
   always_comb begin
      bus.idle        = 2'b00;
      bus.round_reset = 1'b0;
      bus.match_over  = 1'b0;
      bus.champion    = 2'b00;
      unique case (state)
         ST_PLAY: ;
         ST_HOLD: bus.idle = 2'b01;
         ST_CLEAR: begin
            bus.idle        = 2'b01;
            bus.round_reset = 1'b1;
         end
         ST_DONE: begin
            bus.idle       = 2'b11;
            bus.match_over = 1'b1;
            if (cnt_l == WIN_CNT)      bus.champion = 2'b01;
            else if (cnt_r == WIN_CNT) bus.champion = 2'b10;
         end
         default: ;
      endcase
   end

   tow_seg7 u_seg_l (.value(cnt_l), .seg(bus.hex_l));
   tow_seg7 u_seg_r (.value(cnt_r), .seg(bus.hex_r));

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed bench for tow_match_ctrl with default parameters (7 rounds, 4-cycle hold).
module tb_tow_match_ctrl;

   localparam logic [6:0] D0 = 7'b1000000;
   localparam logic [6:0] D1 = 7'b1111001;
   localparam logic [6:0] D7 = 7'b1111000;

   logic [6:0] digits [0:7] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fails  = 0;

   tow_match_ctrl_if bus ();

   tow_match_ctrl #(.WIN_ROUNDS(7), .HOLD_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and let outputs settle before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.win_l = 1'b0;
      bus.win_r = 1'b0;
      bus.start = 1'b0;

      // Reset held low for two edges.
      step();
      step();
      check("rst_hex_l", bus.hex_l, D0);
      check("rst_hex_r", bus.hex_r, D0);
      check("rst_idle", 7'(bus.idle), 7'd0);
      check("rst_champion", 7'(bus.champion), 7'd0);
      check("rst_round_reset", 7'(bus.round_reset), 7'd0);
      check("rst_match_over", 7'(bus.match_over), 7'd0);
      reset = 1'b1;
      step();

      // Left win flag held high six cycles: one round only.
      bus.win_l = 1'b1;
      step();
      check("l_hex_l_1", bus.hex_l, D1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) step();
         check("l_hold_idle", 7'(bus.idle), 7'b01);
         check("l_hold_rr", 7'(bus.round_reset), 7'd0);
      end
      step();
      check("l_clear_rr", 7'(bus.round_reset), 7'd1);
      check("l_clear_idle", 7'(bus.idle), 7'b01);
      step();
      check("l_play_idle", 7'(bus.idle), 7'b00);
      check("l_play_rr", 7'(bus.round_reset), 7'd0);
      bus.win_l = 1'b0;
      step();
      check("l_count_once", bus.hex_l, D1);
      check("l_still_play", 7'(bus.idle), 7'b00);

      // Simultaneous rise: tie, clear next cycle, no hold.
      bus.win_l = 1'b1;
      bus.win_r = 1'b1;
      step();
      check("tie_rr", 7'(bus.round_reset), 7'd1);
      check("tie_hex_l", bus.hex_l, D1);
      check("tie_hex_r", bus.hex_r, D0);
      bus.win_l = 1'b0;
      bus.win_r = 1'b0;
      step();
      check("tie_play_idle", 7'(bus.idle), 7'b00);
      check("tie_play_rr", 7'(bus.round_reset), 7'd0);

      // Seven right-side rounds take the match.
      for (int r = 1; r <= 7; r++) begin
         bus.win_r = 1'b1;
         step();
         check("r_round_hex_r", bus.hex_r, digits[r]);
         bus.win_r = 1'b0;
         for (int k = 0; k < 5; k++) step();
      end
      check("done_hex_r", bus.hex_r, D7);
      check("done_match_over", 7'(bus.match_over), 7'd1);
      check("done_idle", 7'(bus.idle), 7'b11);
      check("done_champion", 7'(bus.champion), 7'b10);

      // Left edges in DONE are discarded.
      bus.win_l = 1'b1;
      step();
      bus.win_l = 1'b0;
      step();
      step();
      check("done_ignore_hex_l", bus.hex_l, D1);
      check("done_ignore_idle", 7'(bus.idle), 7'b11);

      // New match request.
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      check("start_rr", 7'(bus.round_reset), 7'd1);
      check("start_hex_l", bus.hex_l, D0);
      check("start_hex_r", bus.hex_r, D0);
      check("start_champion", 7'(bus.champion), 7'd0);
      check("start_match_over", 7'(bus.match_over), 7'd0);
      step();
      check("start_play_idle", 7'(bus.idle), 7'b00);
      check("start_play_rr", 7'(bus.round_reset), 7'd0);
      step();
      check("start_single_pulse", 7'(bus.round_reset), 7'd0);

      // Reset during the second HOLD cycle.
      bus.win_l = 1'b1;
      step();
      check("hold_rst_hex_l_pre", bus.hex_l, D1);
      step();
      check("hold_rst_in_hold", 7'(bus.idle), 7'b01);
      reset = 1'b0;
      step();
      check("hold_rst_idle", 7'(bus.idle), 7'b00);
      check("hold_rst_hex_l", bus.hex_l, D0);
      check("hold_rst_rr", 7'(bus.round_reset), 7'd0);
      reset = 1'b1;
      bus.win_l = 1'b0;
      step();
      check("hold_rst_rr_next", 7'(bus.round_reset), 7'd0);
      check("hold_rst_play", 7'(bus.idle), 7'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
